// File: rtl/mac_wr_req_arbiter.sv
// Multi-channel write-request front end: per-channel 1-deep header slots, QoS/round-robin
// arbitration, and whole-burst forwarding to one MAC write port with length/timeout checking.
module mac_wr_req_arbiter #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned MASK_W = DATA_W / 8,
  localparam int unsigned GNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        iWR_Valid,
  input  logic [NUM_CH*ADDR_W-1:0] iWR_Addr,
  input  logic [NUM_CH*4-1:0]      iWR_Tag,
  input  logic [NUM_CH*3-1:0]      iWR_Id,
  input  logic [NUM_CH*2-1:0]      iWR_Len,
  input  logic [NUM_CH*4-1:0]      iWR_QoS,
  output logic [NUM_CH-1:0]        oWR_Ready,
  input  logic [NUM_CH-1:0]        iWR_DValid,
  input  logic [NUM_CH*DATA_W-1:0] iWR_Data,
  input  logic [NUM_CH*MASK_W-1:0] iWR_Mask,
  input  logic [NUM_CH-1:0]        iWR_EoD,
  output logic [NUM_CH-1:0]        oWR_DReady,
  output logic                     oMAC_ValidWr,
  output logic [ADDR_W-1:0]        oMAC_AddrWr,
  output logic [3:0]               oMAC_TagWr,
  output logic [2:0]               oMAC_IdWr,
  output logic [1:0]               oMAC_LenWr,
  output logic [3:0]               oMAC_QoSWr,
  input  logic                     iMAC_ReadyWr,
  output logic                     oMAC_DValid,
  output logic [DATA_W-1:0]        oMAC_DataWr,
  output logic [MASK_W-1:0]        oMAC_MaskWr,
  output logic                     oMAC_EoD,
  input  logic                     iMAC_DReady,
  output logic [GNT_W-1:0]         oGrant,
  output logic                     oErr_Len
);

  localparam int unsigned      TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TmrEn  = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TmrMax = TMR_W'(TIMEOUT);
  localparam logic [GNT_W-1:0] LastCh = GNT_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StArb, StHdr, StData} state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0] full_q, full_d, ready_q, cap, free;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [3:0]        tag_q  [NUM_CH];
  logic [2:0]        id_q   [NUM_CH];
  logic [1:0]        len_q  [NUM_CH];
  logic [3:0]        qos_q  [NUM_CH];
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [MASK_W-1:0] ch_mask [NUM_CH];

  logic [GNT_W-1:0] grant_q, grant_d, rr_q, rr_d, arb_gnt, cand;
  logic [2:0]       cnt_q, cnt_d, exp_q, exp_d;
  logic [TMR_W-1:0] idle_q, idle_d;
  logic             err_q, err_d;
  logic [3:0]       best_qos;
  logic             found;
  int               idx;
  logic             dval_g, eod_g, last_beat, timed_out;

  function automatic logic [2:0] len_beats(input logic [1:0] len);
    case (len)
      2'b10:   len_beats = 3'd2;
      2'b11:   len_beats = 3'd4;
      default: len_beats = 3'd1;
    endcase
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_data[c] = iWR_Data[c*DATA_W +: DATA_W];
    assign ch_mask[c] = iWR_Mask[c*MASK_W +: MASK_W];
  end

  // A slot can never be captured and freed in the same cycle: capture needs it empty.
  always_comb begin
    cap    = iWR_Valid & ready_q;
    full_d = (full_q | cap) & ~free;
  end

  // ready_q mirrors ~full_q but stays low while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q  <= '0;
      ready_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_q[c] <= '0;
        tag_q[c]  <= '0;
        id_q[c]   <= '0;
        len_q[c]  <= '0;
        qos_q[c]  <= '0;
      end
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c]) begin
          addr_q[c] <= iWR_Addr[c*ADDR_W +: ADDR_W];
          tag_q[c]  <= iWR_Tag[c*4 +: 4];
          id_q[c]   <= iWR_Id[c*3 +: 3];
          len_q[c]  <= iWR_Len[c*2 +: 2];
          qos_q[c]  <= iWR_QoS[c*4 +: 4];
        end
      end
    end
  end

  // Scan from the RR pointer; strict '>' keeps the earliest slot on QoS ties.
  always_comb begin
    arb_gnt  = '0;
    best_qos = '0;
    found    = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx  = (int'(rr_q) + i) % int'(NUM_CH);
      cand = GNT_W'(idx);
      if (full_q[cand] && (!found || qos_q[cand] > best_qos)) begin
        found    = 1'b1;
        best_qos = qos_q[cand];
        arb_gnt  = cand;
      end
    end
  end

  assign dval_g    = iWR_DValid[grant_q];
  assign eod_g     = iWR_EoD[grant_q];
  assign last_beat = (cnt_q + 3'd1 == exp_q);
  assign timed_out = TmrEn && (idle_q == TmrMax);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    idle_d       = idle_q;
    err_d        = 1'b0;
    free         = '0;
    oWR_DReady   = '0;
    oMAC_ValidWr = 1'b0;
    oMAC_AddrWr  = '0;
    oMAC_TagWr   = '0;
    oMAC_IdWr    = '0;
    oMAC_LenWr   = '0;
    oMAC_QoSWr   = '0;
    oMAC_DValid  = 1'b0;
    oMAC_DataWr  = '0;
    oMAC_MaskWr  = '0;
    oMAC_EoD     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|full_q) state_d = StArb;
      end
      StArb: begin
        grant_d = arb_gnt;
        rr_d    = (arb_gnt == LastCh) ? '0 : arb_gnt + 1'b1;
        state_d = StHdr;
      end
      StHdr: begin
        oMAC_ValidWr = 1'b1;
        oMAC_AddrWr  = addr_q[grant_q];
        oMAC_TagWr   = tag_q[grant_q];
        oMAC_IdWr    = id_q[grant_q];
        oMAC_LenWr   = len_q[grant_q];
        oMAC_QoSWr   = qos_q[grant_q];
        if (iMAC_ReadyWr) begin
          free[grant_q] = 1'b1;
          cnt_d         = '0;
          idle_d        = '0;
          exp_d         = len_beats(len_q[grant_q]);
          state_d       = StData;
        end
      end
      StData: begin
        if (timed_out) begin
          // Upstream went silent: close the burst with an empty terminating beat.
          oMAC_DValid = 1'b1;
          oMAC_EoD    = 1'b1;
          if (iMAC_DReady) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else begin
          oMAC_DValid         = dval_g;
          oWR_DReady[grant_q] = iMAC_DReady;
          oMAC_DataWr         = ch_data[grant_q];
          oMAC_MaskWr         = ch_mask[grant_q];
          oMAC_EoD            = eod_g | last_beat;
          if (dval_g && iMAC_DReady) begin
            idle_d = '0;
            if (eod_g || last_beat) begin
              err_d   = eod_g ^ last_beat;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else if (TmrEn && !dval_g) begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  assign oWR_Ready = ready_q;
  assign oGrant    = grant_q;
  assign oErr_Len  = err_q;

endmodule

// File: tb/tb_mac_wr_req_arbiter.sv
// Directed bench for mac_wr_req_arbiter: upstream header/data drivers plus a MAC-side
// recorder; expectations are hand-computed per scenario.
module tb_mac_wr_req_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   iWR_Valid, oWR_Ready, iWR_DValid, iWR_EoD, oWR_DReady;
  logic [127:0] iWR_Addr, iWR_Data;
  logic [15:0]  iWR_Tag, iWR_QoS, iWR_Mask;
  logic [11:0]  iWR_Id;
  logic [7:0]   iWR_Len;
  logic         oMAC_ValidWr, iMAC_ReadyWr, oMAC_DValid, oMAC_EoD, iMAC_DReady, oErr_Len;
  logic [31:0]  oMAC_AddrWr, oMAC_DataWr;
  logic [3:0]   oMAC_TagWr, oMAC_QoSWr, oMAC_MaskWr;
  logic [2:0]   oMAC_IdWr;
  logic [1:0]   oMAC_LenWr, oGrant;

  mac_wr_req_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .iWR_Valid(iWR_Valid), .iWR_Addr(iWR_Addr), .iWR_Tag(iWR_Tag), .iWR_Id(iWR_Id),
    .iWR_Len(iWR_Len), .iWR_QoS(iWR_QoS), .oWR_Ready(oWR_Ready),
    .iWR_DValid(iWR_DValid), .iWR_Data(iWR_Data), .iWR_Mask(iWR_Mask), .iWR_EoD(iWR_EoD),
    .oWR_DReady(oWR_DReady),
    .oMAC_ValidWr(oMAC_ValidWr), .oMAC_AddrWr(oMAC_AddrWr), .oMAC_TagWr(oMAC_TagWr),
    .oMAC_IdWr(oMAC_IdWr), .oMAC_LenWr(oMAC_LenWr), .oMAC_QoSWr(oMAC_QoSWr),
    .iMAC_ReadyWr(iMAC_ReadyWr),
    .oMAC_DValid(oMAC_DValid), .oMAC_DataWr(oMAC_DataWr), .oMAC_MaskWr(oMAC_MaskWr),
    .oMAC_EoD(oMAC_EoD), .iMAC_DReady(iMAC_DReady),
    .oGrant(oGrant), .oErr_Len(oErr_Len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  tag;
    logic [2:0]  id;
    logic [1:0]  len;
    logic [3:0]  qos;
    logic [1:0]  g;
  } hdr_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        eod;
    logic [31:0] cyc;
  } beat_t;

  hdr_t        hq[$];
  beat_t       bq[$];
  int          err_cnt = 0;
  logic [31:0] cyc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hb, bb, eb;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // MAC-side recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (oMAC_ValidWr && iMAC_ReadyWr)
        hq.push_back('{oMAC_AddrWr, oMAC_TagWr, oMAC_IdWr, oMAC_LenWr, oMAC_QoSWr, oGrant});
      if (oMAC_DValid && iMAC_DReady)
        bq.push_back('{oMAC_DataWr, oMAC_MaskWr, oMAC_EoD, cyc});
      if (oErr_Len) err_cnt = err_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_hdr(input int ch, input logic [31:0] a, input logic [3:0] tg,
                          input logic [2:0] id, input logic [1:0] ln, input logic [3:0] q);
    int t;
    iWR_Addr[ch*32 +: 32] = a;
    iWR_Tag[ch*4 +: 4]    = tg;
    iWR_Id[ch*3 +: 3]     = id;
    iWR_Len[ch*2 +: 2]    = ln;
    iWR_QoS[ch*4 +: 4]    = q;
    iWR_Valid[ch]         = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!oWR_Ready[ch] && t < 300);
    check_eq("hdr_accept", 64'(oWR_Ready[ch]), 64'd1);
    @(posedge clk); #1;
    iWR_Valid[ch] = 1'b0;
  endtask

  task automatic feed(input int ch, input int n, input logic [127:0] d, input logic [15:0] m,
                      input logic [3:0] e);
    for (int i = 0; i < n; i++) begin
      int t;
      iWR_DValid[ch]        = 1'b1;
      iWR_Data[ch*32 +: 32] = d[i*32 +: 32];
      iWR_Mask[ch*4 +: 4]   = m[i*4 +: 4];
      iWR_EoD[ch]           = e[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!oWR_DReady[ch] && t < 300);
      check_eq("beat_accept", 64'(oWR_DReady[ch]), 64'd1);
      @(posedge clk); #1;
    end
    iWR_DValid[ch] = 1'b0;
    iWR_EoD[ch]    = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int t;
    t = 0;
    while (bq.size() < target && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic mark();
    hb = hq.size();
    bb = bq.size();
    eb = err_cnt;
  endtask

  logic [1:0]  rr_exp [5];
  logic [31:0] rr_dat [5];

  initial begin
    resetn = 1'b0;
    iWR_Valid = '0; iWR_Addr = '0; iWR_Tag = '0; iWR_Id = '0; iWR_Len = '0; iWR_QoS = '0;
    iWR_DValid = '0; iWR_Data = '0; iWR_Mask = '0; iWR_EoD = '0;
    iMAC_ReadyWr = 1'b1; iMAC_DReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(oWR_Ready), 64'h0);
    check_eq("rst_validwr", 64'(oMAC_ValidWr), 64'h0);
    check_eq("rst_grant", 64'(oGrant), 64'h0);
    check_eq("rst_err", 64'(oErr_Len), 64'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_ready", 64'(oWR_Ready), 64'hF);

    // Round-robin among equal QoS, ch0 re-requests.
    mark();
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_dat = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0010};
    fork
      begin
        send_hdr(0, 32'h0000_1000, 4'h0, 3'd0, 2'b01, 4'd5);
        send_hdr(0, 32'h0000_1010, 4'h1, 3'd0, 2'b01, 4'd5);
      end
      begin
        feed(0, 1, 128'h1000_0000, 16'hF, 4'b1);
        feed(0, 1, 128'h1000_0010, 16'hF, 4'b1);
      end
      send_hdr(1, 32'h0000_2000, 4'h2, 3'd1, 2'b01, 4'd5);
      feed(1, 1, 128'h1000_0001, 16'hF, 4'b1);
      send_hdr(2, 32'h0000_3000, 4'h3, 3'd2, 2'b01, 4'd5);
      feed(2, 1, 128'h1000_0002, 16'hF, 4'b1);
      send_hdr(3, 32'h0000_4000, 4'h4, 3'd3, 2'b01, 4'd5);
      feed(3, 1, 128'h1000_0003, 16'hF, 4'b1);
    join
    wait_beats(bb + 5);
    check_eq("rr_nhdr", 64'(hq.size() - hb), 64'd5);
    if (hq.size() - hb == 5 && bq.size() - bb == 5) begin
      for (int i = 0; i < 5; i++) begin
        check_eq("rr_grant", 64'(hq[hb+i].g), 64'(rr_exp[i]));
        check_eq("rr_data", 64'(bq[bb+i].data), 64'(rr_dat[i]));
      end
    end else begin
      check_eq("rr_nbeats", 64'(bq.size() - bb), 64'd5);
    end
    check_eq("rr_err", 64'(err_cnt - eb), 64'd0);

    // Single ch0, Len=10, two beats with EoD on the second.
    mark();
    fork
      send_hdr(0, 32'h2345_F000, 4'hA, 3'b101, 2'b10, 4'b0110);
      feed(0, 2, {64'h0, 32'hCBCD_EF12, 32'hABCD_EF12}, {8'h0, 4'b1011, 4'b1101}, 4'b0010);
    join
    wait_beats(bb + 2);
    check_eq("t1_nhdr", 64'(hq.size() - hb), 64'd1);
    check_eq("t1_nbeats", 64'(bq.size() - bb), 64'd2);
    if (hq.size() - hb >= 1) begin
      check_eq("t1_addr", 64'(hq[hb].addr), 64'h2345_F000);
      check_eq("t1_tag", 64'(hq[hb].tag), 64'hA);
      check_eq("t1_id", 64'(hq[hb].id), 64'b101);
      check_eq("t1_len", 64'(hq[hb].len), 64'b10);
      check_eq("t1_qos", 64'(hq[hb].qos), 64'b0110);
      check_eq("t1_grant", 64'(hq[hb].g), 64'd0);
    end
    if (bq.size() - bb >= 2) begin
      check_eq("t1_b0", 64'({bq[bb].data, bq[bb].mask, bq[bb].eod}), {28'h0, 32'hABCD_EF12, 4'b1101, 1'b0});
      check_eq("t1_b1", 64'({bq[bb+1].data, bq[bb+1].mask, bq[bb+1].eod}), {28'h0, 32'hCBCD_EF12, 4'b1011, 1'b1});
    end
    check_eq("t1_err", 64'(err_cnt - eb), 64'd0);

    // QoS priority: ch2 (9) beats ch1 (3).
    mark();
    fork
      send_hdr(1, 32'h0000_1100, 4'h1, 3'd1, 2'b01, 4'd3);
      feed(1, 1, 128'h1111_0001, 16'hF, 4'b1);
      send_hdr(2, 32'h0000_2200, 4'h2, 3'd2, 2'b01, 4'd9);
      feed(2, 1, 128'h2222_0002, 16'hF, 4'b1);
    join
    wait_beats(bb + 2);
    check_eq("qos_nhdr", 64'(hq.size() - hb), 64'd2);
    check_eq("qos_nbeats", 64'(bq.size() - bb), 64'd2);
    if (hq.size() - hb >= 2 && bq.size() - bb >= 2) begin
      check_eq("qos_g0", 64'(hq[hb].g), 64'd2);
      check_eq("qos_g1", 64'(hq[hb+1].g), 64'd1);
      check_eq("qos_d0", 64'(bq[bb].data), 64'h2222_0002);
      check_eq("qos_d1", 64'(bq[bb+1].data), 64'h1111_0001);
    end

    // Early EoD: Len=11, EoD on beat 2.
    mark();
    fork
      send_hdr(3, 32'h0000_3300, 4'h3, 3'd3, 2'b11, 4'd1);
      feed(3, 2, {64'h0, 32'h3333_0002, 32'h3333_0001}, {8'h0, 4'h3, 4'hF}, 4'b0010);
    join
    wait_beats(bb + 2);
    check_eq("early_nbeats", 64'(bq.size() - bb), 64'd2);
    if (bq.size() - bb >= 2)
      check_eq("early_b1", 64'({bq[bb+1].data, bq[bb+1].mask, bq[bb+1].eod}), {28'h0, 32'h3333_0002, 4'h3, 1'b1});
    check_eq("early_err", 64'(err_cnt - eb), 64'd1);
    check_eq("early_idle", 64'({oMAC_ValidWr, oMAC_DValid, oWR_DReady}), 64'h0);

    // Missing EoD: Len=10, no EoD; a third beat must not be consumed.
    mark();
    fork
      send_hdr(0, 32'h0000_5500, 4'h5, 3'd0, 2'b10, 4'd1);
      feed(0, 2, {64'h0, 32'h5555_0006, 32'h5555_0005}, {8'h0, 4'hF, 4'hF}, 4'b0000);
    join
    iWR_DValid[0] = 1'b1;
    iWR_Data[31:0] = 32'h5555_0007;
    iWR_EoD[0] = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("noeod_no_consume", 64'(oWR_DReady[0]), 64'd0);
    @(posedge clk); #1;
    iWR_DValid[0] = 1'b0;
    iWR_EoD[0] = 1'b0;
    wait_beats(bb + 2);
    check_eq("noeod_nbeats", 64'(bq.size() - bb), 64'd2);
    if (bq.size() - bb >= 2) begin
      check_eq("noeod_b0_eod", 64'(bq[bb].eod), 64'd0);
      check_eq("noeod_b1_eod", 64'(bq[bb+1].eod), 64'd1);
    end
    check_eq("noeod_err", 64'(err_cnt - eb), 64'd1);

    // Timeout: one beat then silence, TIMEOUT=8.
    mark();
    fork
      send_hdr(1, 32'h0000_6600, 4'h6, 3'd1, 2'b10, 4'd1);
      feed(1, 1, 128'h6666_0001, 16'hF, 4'b0);
    join
    wait_beats(bb + 2);
    check_eq("to_nbeats", 64'(bq.size() - bb), 64'd2);
    if (bq.size() - bb >= 2) begin
      check_eq("to_beat", 64'({bq[bb+1].data, bq[bb+1].mask, bq[bb+1].eod}), 64'h1);
      check_eq("to_delay", 64'(bq[bb+1].cyc - bq[bb].cyc), 64'd9);
    end
    check_eq("to_err", 64'(err_cnt - eb), 64'd1);

    // Header stall: MAC not ready for 5 cycles.
    mark();
    iMAC_ReadyWr = 1'b0;
    send_hdr(2, 32'hDEAD_0040, 4'h7, 3'd2, 2'b01, 4'd1);
    begin
      int t;
      t = 0;
      while (!oMAC_ValidWr && t < 50) begin @(negedge clk); t++; end
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_addr", 64'({oMAC_ValidWr, oMAC_AddrWr}), {31'h0, 1'b1, 32'hDEAD_0040});
      check_eq("stall_ready", 64'(oWR_Ready[2]), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    iMAC_ReadyWr = 1'b1;
    feed(2, 1, 128'h7777_0001, 16'hF, 4'b1);
    wait_beats(bb + 1);
    check_eq("stall_nhdr", 64'(hq.size() - hb), 64'd1);
    check_eq("stall_nbeats", 64'(bq.size() - bb), 64'd1);

    // Reset in the middle of beat 1 of a 4-beat burst.
    mark();
    iMAC_DReady = 1'b0;
    send_hdr(1, 32'h0000_8000, 4'h8, 3'd1, 2'b11, 4'd2);
    iWR_DValid[1] = 1'b1;
    iWR_Data[63:32] = 32'h8888_0001;
    iWR_Mask[7:4] = 4'hF;
    begin
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!oMAC_DValid && t < 50);
    end
    check_eq("rst_mid_in_data", 64'(oMAC_DValid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_mid_dvalid", 64'({oMAC_DValid, oMAC_EoD, oMAC_DataWr}), 64'h0);
    check_eq("rst_mid_dready", 64'(oWR_DReady), 64'h0);
    check_eq("rst_mid_ready", 64'(oWR_Ready), 64'h0);
    check_eq("rst_mid_grant", 64'(oGrant), 64'h0);
    iWR_DValid = '0;
    iMAC_DReady = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_slots", 64'(oWR_Ready), 64'hF);
    repeat (3) @(negedge clk);
    check_eq("rst_mid_idle", 64'({oMAC_ValidWr, oMAC_DValid}), 64'h0);
    check_eq("rst_mid_nbeats", 64'(bq.size() - bb), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
